// File: rtl/led_seq_pkg.sv
// Shared pattern codes, rate-select encoding and sequencer state for led_sequencer_gen.
// Pure declarations; no latency or backpressure of its own.
package led_seq_pkg;

  localparam logic [3:0] PAT_WALK1 = 4'd0;
  localparam logic [3:0] PAT_WALK0 = 4'd1;
  localparam logic [3:0] PAT_PING  = 4'd2;
  localparam logic [3:0] PAT_BIN   = 4'd3;
  localparam logic [3:0] PAT_FILL  = 4'd4;
  localparam logic [3:0] PAT_ALT   = 4'd5;
  localparam logic [3:0] PAT_GRAY  = 4'd6;
  localparam logic [3:0] PAT_LFSR  = 4'd7;
  localparam logic [3:0] PAT_OFF   = 4'd8;

  typedef enum logic [1:0] {
    RATE_0 = 2'd0,
    RATE_1 = 2'd1,
    RATE_2 = 2'd2,
    RATE_3 = 2'd3
  } rate_sel_t;

  // IDLE means no frame has been shown since reset; the first advance always loads a pattern.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

  function automatic logic pat_is_reversible(input logic [3:0] pat);
    return (pat == PAT_WALK1) || (pat == PAT_WALK0) || (pat == PAT_BIN) || (pat == PAT_GRAY);
  endfunction

endpackage

// File: rtl/led_seq_prescaler.sv
// Step-rate prescaler: one-cycle tick every DIVn clocks; cleared on a rate change, frozen on pause.
// Tick is combinational from the count register; no backpressure.
module led_seq_prescaler
  import led_seq_pkg::*;
#(
  parameter int PRESC_W = 24,
  parameter int DIV0    = 1000000,
  parameter int DIV1    = 2500000,
  parameter int DIV2    = 5000000,
  parameter int DIV3    = 10000000
) (
  input  logic       clk_10MHz,
  input  logic       rst,
  input  logic [1:0] clk_selector,
  input  logic       pause,
  output logic       tick
);

  rate_sel_t          sel_q;
  logic [PRESC_W-1:0] count;
  logic [PRESC_W-1:0] div_m1;
  logic               sel_chg;

  always_comb begin
    div_m1 = PRESC_W'(DIV0 - 1);
    case (sel_q)
      RATE_0:  div_m1 = PRESC_W'(DIV0 - 1);
      RATE_1:  div_m1 = PRESC_W'(DIV1 - 1);
      RATE_2:  div_m1 = PRESC_W'(DIV2 - 1);
      RATE_3:  div_m1 = PRESC_W'(DIV3 - 1);
      default: div_m1 = PRESC_W'(DIV0 - 1);
    endcase
  end

  // A rate change suppresses the tick even if the old count had just matched.
  assign sel_chg = (clk_selector != sel_q);
  assign tick    = !pause && !sel_chg && (count == div_m1);

  always_ff @(posedge clk_10MHz or posedge rst) begin
    if (rst) begin
      sel_q <= RATE_0;
      count <= '0;
    end else begin
      sel_q <= rate_sel_t'(clk_selector);
      if (sel_chg || tick) begin
        count <= '0;
      end else if (!pause) begin
        count <= count + PRESC_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_sequencer_gen.sv
// Parametrised LED pattern sequencer; frame and tick_out register one clock after each advance.
// Free-running, no backpressure: pattern switches apply only at advance boundaries.
module led_sequencer_gen
  import led_seq_pkg::*;
#(
  parameter int               LED_W     = 8,
  parameter int               PRESC_W   = 24,
  parameter int               DIV0      = 1000000,
  parameter int               DIV1      = 2500000,
  parameter int               DIV2      = 5000000,
  parameter int               DIV3      = 10000000,
  parameter logic [LED_W-1:0] LFSR_TAPS = LED_W'(8'hB8)
) (
  input  logic             clk_10MHz,
  input  logic             rst,
  input  logic [1:0]       clk_selector,
  input  logic [3:0]       pattern_sel,
  input  logic             dir,
  input  logic             pause,
  input  logic             step,
  output logic [LED_W-1:0] led_out,
  output logic             tick_out
);

  function automatic logic [LED_W-1:0] alt_pattern();
    logic [LED_W-1:0] f;
    f = '0;
    for (int i = 0; i < LED_W; i++) f[i] = i[0];
    return f;
  endfunction

  localparam logic [LED_W-1:0] ONE       = LED_W'(1);
  localparam logic [LED_W-1:0] ONES      = '1;
  localparam logic [LED_W-1:0] W_V       = LED_W'(LED_W);
  localparam logic [LED_W-1:0] WALK_LAST = LED_W'(LED_W - 1);
  localparam logic [LED_W-1:0] PING_TOP  = LED_W'(2 * LED_W - 2);
  localparam logic [LED_W-1:0] PING_LAST = LED_W'(2 * LED_W - 3);
  localparam logic [LED_W-1:0] FILL_LAST = LED_W'(2 * LED_W - 1);
  localparam logic [LED_W-1:0] ALT_EVEN  = alt_pattern();

  // Last index of each pattern's period; wrap is explicit so idx never runs off a short cycle.
  function automatic logic [LED_W-1:0] step_idx(input logic [3:0] pat, input logic [LED_W-1:0] idx,
                                                input logic rev);
    logic [LED_W-1:0] last;
    last = '0;
    case (pat)
      PAT_WALK1, PAT_WALK0: last = WALK_LAST;
      PAT_PING:             last = PING_LAST;
      PAT_BIN, PAT_GRAY:    last = ONES;
      PAT_FILL:             last = FILL_LAST;
      PAT_ALT:              last = ONE;
      default:              last = '0;
    endcase
    if (rev && pat_is_reversible(pat)) return (idx == '0) ? last : idx - ONE;
    return (idx == last) ? '0 : idx + ONE;
  endfunction

  function automatic logic [LED_W-1:0] frame(input logic [3:0] pat, input logic [LED_W-1:0] idx,
                                             input logic [LED_W-1:0] lfsr_v);
    logic [LED_W-1:0] f;
    logic [LED_W-1:0] p;
    f = '0;
    p = (idx < W_V) ? idx : PING_TOP - idx;
    case (pat)
      PAT_WALK1: f = ONE << idx;
      PAT_WALK0: f = ~(ONE << idx);
      PAT_PING:  f = ONE << p;
      PAT_BIN:   f = idx;
      PAT_FILL:  f = (idx < W_V) ? (ONES >> (WALK_LAST - idx)) : (ONES << (idx - WALK_LAST));
      PAT_ALT:   f = idx[0] ? ~ALT_EVEN : ALT_EVEN;
      PAT_GRAY:  f = idx ^ (idx >> 1);
      PAT_LFSR:  f = lfsr_v;
      default:   f = '0;
    endcase
    return f;
  endfunction

  seq_state_t       state, state_nxt;
  logic [3:0]       active_pat, pat_nxt;
  logic [LED_W-1:0] idx, idx_nxt, idx_step;
  logic [LED_W-1:0] lfsr, lfsr_nxt, lfsr_step;
  logic [LED_W-1:0] led_nxt;
  logic             tick_nxt;
  logic             presc_tick;
  logic             advance;

  led_seq_prescaler #(
    .PRESC_W (PRESC_W),
    .DIV0    (DIV0),
    .DIV1    (DIV1),
    .DIV2    (DIV2),
    .DIV3    (DIV3)
  ) u_prescaler (
    .clk_10MHz    (clk_10MHz),
    .rst          (rst),
    .clk_selector (clk_selector),
    .pause        (pause),
    .tick         (presc_tick)
  );

  assign advance = presc_tick || (pause && step);

  always_comb begin
    state_nxt = state;
    pat_nxt   = active_pat;
    idx_nxt   = idx;
    lfsr_nxt  = lfsr;
    led_nxt   = led_out;
    tick_nxt  = advance;
    idx_step  = step_idx(active_pat, idx, dir);
    lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
    if (advance) begin
      state_nxt = ST_RUN;
      if (state == ST_IDLE || pattern_sel != active_pat) begin
        pat_nxt  = pattern_sel;
        idx_nxt  = '0;
        lfsr_nxt = ONE;
        led_nxt  = frame(pattern_sel, '0, ONE);
      end else begin
        idx_nxt = idx_step;
        if (active_pat == PAT_LFSR) lfsr_nxt = lfsr_step;
        led_nxt = frame(active_pat, idx_step, lfsr_nxt);
      end
    end
  end

  always_ff @(posedge clk_10MHz or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      active_pat <= PAT_WALK1;
      idx        <= '0;
      lfsr       <= ONE;
      led_out    <= '0;
      tick_out   <= 1'b0;
    end else begin
      state      <= state_nxt;
      active_pat <= pat_nxt;
      idx        <= idx_nxt;
      lfsr       <= lfsr_nxt;
      led_out    <= led_nxt;
      tick_out   <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_led_sequencer_gen.sv
// Scoreboard bench for led_sequencer_gen: a spec-level model queues expected frames, a monitor checks them.
module tb_led_sequencer_gen;

  logic       clk_10MHz = 1'b0;
  logic       rst;
  logic [1:0] clk_selector;
  logic [3:0] pattern_sel;
  logic       dir;
  logic       pause;
  logic       step;
  logic [7:0] led_out;
  logic       tick_out;

  always #5 clk_10MHz = ~clk_10MHz;

  led_sequencer_gen #(
    .LED_W     (8),
    .PRESC_W   (24),
    .DIV0      (4),
    .DIV1      (8),
    .DIV2      (16),
    .DIV3      (32),
    .LFSR_TAPS (8'hB8)
  ) dut (
    .clk_10MHz    (clk_10MHz),
    .rst          (rst),
    .clk_selector (clk_selector),
    .pattern_sel  (pattern_sel),
    .dir          (dir),
    .pause        (pause),
    .step         (step),
    .led_out      (led_out),
    .tick_out     (tick_out)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_led = 8'h00;
  logic [7:0] mon_e;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int DIVS[4] = '{4, 8, 16, 32};
  int m_cnt, m_rate, m_pat, m_pos;
  bit m_started, m_adv;
  logic [7:0] m_lfsr;

  function automatic int ref_period(input int pat);
    case (pat)
      0, 1:    return 8;
      2:       return 14;
      3, 6:    return 256;
      4:       return 16;
      5:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic logic [7:0] ref_frame(input int pat, input int k);
    int p;
    case (pat)
      0: return 8'(1 << k);
      1: return 8'(~(1 << k));
      2: begin p = (k < 8) ? k : 14 - k; return 8'(1 << p); end
      3: return 8'(k);
      4: return (k < 8) ? 8'((1 << (k + 1)) - 1) : 8'(255 << (k - 7));
      5: return (k % 2 == 0) ? 8'hAA : 8'h55;
      6: return 8'(k ^ (k >> 1));
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk_10MHz) begin
    if (rst) begin
      m_cnt = 0; m_rate = 0; m_pat = 0; m_pos = 0; m_started = 0; m_lfsr = 8'h01;
      exp_q.delete();
    end else begin
      m_adv = 0;
      if (int'(clk_selector) != m_rate) begin
        m_rate = int'(clk_selector);
        m_cnt  = 0;
      end else if (!pause) begin
        if (m_cnt == DIVS[m_rate] - 1) begin m_adv = 1; m_cnt = 0; end
        else m_cnt++;
      end
      if (pause && step) m_adv = 1;
      if (m_adv) begin
        if (!m_started || int'(pattern_sel) != m_pat) begin
          m_started = 1; m_pat = int'(pattern_sel); m_pos = 0; m_lfsr = 8'h01;
        end else if (m_pat == 7) begin
          m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
        end else begin
          m_pos = (m_pos + ((dir && (m_pat inside {0, 1, 3, 6})) ? ref_period(m_pat) - 1 : 1))
                  % ref_period(m_pat);
        end
        exp_q.push_back((m_pat == 7) ? m_lfsr : ref_frame(m_pat, m_pos));
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk_10MHz) begin
    if (rst) begin
      check("reset_led", led_out, 0);
      check("reset_tick", tick_out, 0);
      exp_q.delete();
      last_led = 8'h00;
    end else begin
      check("tick_out", tick_out, exp_q.size());
      if (tick_out && exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("frame", led_out, mon_e);
        last_led = mon_e;
      end else if (!tick_out) begin
        check("hold", led_out, last_led);
      end
      exp_q.delete();
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(negedge clk_10MHz); #1; end
  endtask

  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin @(negedge clk_10MHz); n++; end while (!tick_out && n < budget);
    if (!tick_out) begin
      n_checks++; n_fail++;
      $display("FAIL wait_tick: no tick_out within %0d cycles", budget);
    end
    #1;
  endtask

  task automatic count_ticks(input int n, output int c);
    c = 0;
    repeat (n) begin @(negedge clk_10MHz); if (tick_out) c++; #1; end
  endtask

  logic [7:0] lfsr_exp[4] = '{8'h01, 8'hB8, 8'h5C, 8'h2E};

  initial begin
    int n, c, c1;
    rst = 1'b1; clk_selector = 2'd0; pattern_sel = 4'd0; dir = 1'b0; pause = 1'b0; step = 1'b0;
    cyc(3);
    rst = 1'b0;
    wait_tick(40, n);
    check("first_tick_latency", n, 4);
    check("first_frame", led_out, 8'h01);
    wait_tick(40, n);
    check("period_sel0", n, 4);
    check("second_frame", led_out, 8'h02);
    cyc(30);
    dir = 1'b1; cyc(24); dir = 1'b0;
    pattern_sel = 4'd2; cyc(70);

    wait_tick(40, n);
    pattern_sel = 4'd7;
    for (int i = 0; i < 4; i++) begin
      wait_tick(40, n);
      check($sformatf("lfsr_frame%0d", i), led_out, lfsr_exp[i]);
    end

    pattern_sel = 4'd0;
    wait_tick(40, n);
    wait_tick(40, n);
    cyc(2);
    pattern_sel = 4'd3;
    cyc(1);
    check("deferred_switch_hold", led_out, 8'h02);
    wait_tick(40, n);
    check("deferred_switch_latency", n, 1);
    check("switch_frame_bin0", led_out, 8'h00);
    wait_tick(40, n);
    check("bin_frame1", led_out, 8'h01);

    pause = 1'b1;
    count_ticks(100, c);
    check("pause_no_ticks", c, 0);
    check("pause_led_stable", led_out, 8'h01);
    c = 0;
    repeat (3) begin
      step = 1'b1; count_ticks(1, c1); c += c1;
      step = 1'b0; count_ticks(3, c1); c += c1;
    end
    check("step_tick_count", c, 3);
    check("step_led", led_out, 8'h04);
    pause = 1'b0;

    wait_tick(40, n);
    cyc(2);
    clk_selector = 2'd2;
    wait_tick(100, n);
    check("sel_change_latency", n, 1 + 16);
    cyc(15);
    clk_selector = 2'd1;
    wait_tick(100, n);
    check("sel_change_in_tick_cycle", n, 1 + 8);
    clk_selector = 2'd0;

    repeat (80) begin
      if ($urandom_range(0, 2) == 0) pattern_sel = 4'($urandom_range(0, 15));
      dir = 1'($urandom_range(0, 1));
      pause = ($urandom_range(0, 5) == 0);
      step = pause ? 1'($urandom_range(0, 1)) : 1'b0;
      if ($urandom_range(0, 9) == 0) clk_selector = 2'($urandom_range(0, 3));
      cyc($urandom_range(1, 8));
      step = 1'b0;
    end

    pattern_sel = 4'd0; dir = 1'b0; pause = 1'b0; step = 1'b0; clk_selector = 2'd0;
    cyc(40);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_led", led_out, 0);
    check("async_rst_tick", tick_out, 0);
    cyc(2);
    rst = 1'b0;
    wait_tick(40, n);
    check("restart_latency", n, 4);
    check("restart_frame", led_out, 8'h01);
    cyc(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
